// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch-stage PC / branch predictor.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
//
// Holds the 2-bit direction counter encoding, the BTB entry layout and the
// default reset vector. The entry layout is sized from PC_WIDTH and
// PC_BTB_ENTRIES below; pc_btb's WIDTH/ENTRIES parameters must match them.
package pc_pkg;

    localparam int unsigned PC_WIDTH       = 32;
    localparam int unsigned PC_BTB_ENTRIES = 16;

    localparam logic [PC_WIDTH-1:0] PC_RESET_VECTOR = 32'h0000_0000;

    // Index selects pc[IDX+1:2]; the tag is everything above it.
    localparam int unsigned BTB_IDX_W = $clog2(PC_BTB_ENTRIES);
    localparam int unsigned BTB_TAG_W = PC_WIDTH - BTB_IDX_W - 2;
    localparam int unsigned BTB_TGT_W = PC_WIDTH - 2;

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } ctr_t;

    // Targets are word aligned, so the low two bits are not stored.
    typedef struct packed {
        logic                 valid;
        logic [BTB_TAG_W-1:0] tag;
        logic [BTB_TGT_W-1:0] target;
        ctr_t                 ctr;
    } btb_entry_t;

    // Saturating step of the direction counter towards the resolved outcome.
    function automatic ctr_t ctr_next(input ctr_t cur, input logic taken);
        ctr_t nxt;
        nxt = cur;
        if (taken) begin
            if (cur != STRONG_T) begin
                nxt = ctr_t'(2'(cur) + 2'd1);
            end
        end else begin
            if (cur != STRONG_NT) begin
                nxt = ctr_t'(2'(cur) - 2'd1);
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/pc_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Latency: lookup is combinational on lookup_pc_i; updates land at the next posedge.
// Backpressure: none; an update is accepted every cycle update_en_i is high.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset (clears valid bits)
//   lookup_pc_i         fetch PC being looked up
//   update_en_i         a branch/jump resolved this cycle
//   update_pc_i         PC of the resolved instruction
//   update_target_i     resolved target
//   update_taken_i      resolved direction
//   hit_taken_o         lookup hit and counter says taken
//   target_o            stored target on a hit, zero otherwise
module pc_btb
    import pc_pkg::*;
#(
    parameter int unsigned WIDTH   = PC_WIDTH,
    parameter int unsigned ENTRIES = PC_BTB_ENTRIES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] lookup_pc_i,
    input  logic             update_en_i,
    input  logic [WIDTH-1:0] update_pc_i,
    input  logic [WIDTH-1:0] update_target_i,
    input  logic             update_taken_i,
    output logic             hit_taken_o,
    output logic [WIDTH-1:0] target_o
);

    localparam int unsigned IDX = $clog2(ENTRIES);

    btb_entry_t mem_q [ENTRIES];

    logic [IDX-1:0]       lk_idx;
    logic [WIDTH-IDX-3:0] lk_tag;
    logic [IDX-1:0]       up_idx;
    logic [WIDTH-IDX-3:0] up_tag;

    btb_entry_t lk_ent;
    btb_entry_t up_ent;
    logic       lk_hit;
    logic       up_hit;
    logic [1:0] lk_ctr;

    assign lk_idx = lookup_pc_i[IDX+1:2];
    assign lk_tag = lookup_pc_i[WIDTH-1:IDX+2];
    assign up_idx = update_pc_i[IDX+1:2];
    assign up_tag = update_pc_i[WIDTH-1:IDX+2];

    // Lookup reads the registered array, so a same-cycle update to the same
    // index is only visible from the following cycle.
    assign lk_ent = mem_q[lk_idx];
    assign lk_ctr = lk_ent.ctr;
    assign lk_hit = lk_ent.valid && (lk_ent.tag == lk_tag);

    assign hit_taken_o = lk_hit && lk_ctr[1];
    assign target_o    = lk_hit ? {lk_ent.target, 2'b00} : '0;

    assign up_ent = mem_q[up_idx];
    assign up_hit = up_ent.valid && (up_ent.tag == up_tag);

    // Only the valid bits are reset; tag/target/counter are don't-care
    // until an allocation sets valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                mem_q[i].valid <= 1'b0;
            end
        end else if (update_en_i) begin
            if (up_hit) begin
                mem_q[up_idx].ctr <= ctr_next(up_ent.ctr, update_taken_i);
                if (update_taken_i) begin
                    mem_q[up_idx].target <= update_target_i[WIDTH-1:2];
                end
            end else if (update_taken_i) begin
                // Not-taken misses never allocate: they would only ever
                // predict fall-through, which is the default anyway.
                mem_q[up_idx] <= '{valid:  1'b1,
                                   tag:    up_tag,
                                   target: update_target_i[WIDTH-1:2],
                                   ctr:    WEAK_T};
            end
        end
    end

    // Byte-offset bits of word-aligned addresses carry no information here.
    logic unused_low_bits;
    assign unused_low_bits = ^{lookup_pc_i[1:0], update_pc_i[1:0], update_target_i[1:0]};

endmodule

// File: rtl/pc_predict_unit.sv
// Fetch-stage PC register with redirect/stall control and BTB-based prediction.
// Latency: PC changes one cycle after its controls; prediction is zero-cycle on pc_o.
// Backpressure: stall_i holds the PC; redirect_i overrides stall; updates never stall.
//
// Build option: define PC_BTB_EN to instantiate the BTB. Without it the unit
// never predicts taken and the update ports are ignored.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   stall_i             hold PC (load-use hazard)
//   redirect_i          execute-stage correction, redirect_pc_i is the new PC
//   update_*_i          branch resolution from execute, trains the BTB
//   pc_o, pc_plus4_o    current fetch PC and its fall-through
//   pred_taken_o        current fetch predicted taken
//   pred_target_o       predicted target (zero when the BTB misses)
module pc_predict_unit
    import pc_pkg::*;
#(
    parameter int unsigned           WIDTH        = PC_WIDTH,
    parameter int unsigned           BTB_ENTRIES  = PC_BTB_ENTRIES,
    parameter logic [WIDTH-1:0]      RESET_VECTOR = PC_RESET_VECTOR
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_i,
    input  logic             redirect_i,
    input  logic [WIDTH-1:0] redirect_pc_i,
    input  logic             update_en_i,
    input  logic [WIDTH-1:0] update_pc_i,
    input  logic [WIDTH-1:0] update_target_i,
    input  logic             update_taken_i,
    output logic [WIDTH-1:0] pc_o,
    output logic [WIDTH-1:0] pc_plus4_o,
    output logic             pred_taken_o,
    output logic [WIDTH-1:0] pred_target_o
);

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] pc_plus4;
    logic             btb_taken;
    logic [WIDTH-1:0] btb_target;

    // Natural modulo-2^WIDTH wrap is intended.
    assign pc_plus4 = pc_q + WIDTH'(4);

`ifdef PC_BTB_EN
    pc_btb #(
        .WIDTH   (WIDTH),
        .ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk             (clk),
        .rst             (rst),
        .lookup_pc_i     (pc_q),
        .update_en_i     (update_en_i),
        .update_pc_i     (update_pc_i),
        .update_target_i (update_target_i),
        .update_taken_i  (update_taken_i),
        .hit_taken_o     (btb_taken),
        .target_o        (btb_target)
    );
`else
    assign btb_taken  = 1'b0;
    assign btb_target = '0;

    logic unused_update;
    assign unused_update = ^{update_en_i, update_pc_i, update_target_i, update_taken_i};
`endif

    // Priority: redirect > stall > predicted taken > fall-through.
    always_comb begin
        pc_d = pc_plus4;
        if (redirect_i) begin
            pc_d = {redirect_pc_i[WIDTH-1:2], 2'b00};
        end else if (stall_i) begin
            pc_d = pc_q;
        end else if (btb_taken) begin
            pc_d = btb_target;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o          = pc_q;
    assign pc_plus4_o    = pc_plus4;
    assign pred_taken_o  = btb_taken;
    assign pred_target_o = btb_target;

    // Redirect targets are forced word aligned.
    logic unused_redir_low;
    assign unused_redir_low = ^redirect_pc_i[1:0];

endmodule

// File: tb/tb_pc_predict_unit.sv
module tb_pc_predict_unit;

`ifdef PC_BTB_EN
    localparam bit B = 1'b1;
`else
    localparam bit B = 1'b0;
`endif

    // Expected BTB target for the 0x10 entry when the BTB is present.
    localparam logic [31:0] T = B ? 32'h80 : 32'h0;
    // Where fetch goes after 0x10 when that entry predicts taken.
    localparam logic [31:0] N10 = B ? 32'h80 : 32'h14;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        update_en_i = 1'b0;
    logic [31:0] update_pc_i = '0;
    logic [31:0] update_target_i = '0;
    logic        update_taken_i = 1'b0;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic        pred_taken_o;
    logic [31:0] pred_target_o;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] pc;
        logic        pt;
        logic [31:0] tgt;
    } exp_t;

    exp_t exp_q[$];

    pc_predict_unit #(
        .WIDTH        (32),
        .BTB_ENTRIES  (16),
        .RESET_VECTOR (32'h0)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall_i),
        .redirect_i      (redirect_i),
        .redirect_pc_i   (redirect_pc_i),
        .update_en_i     (update_en_i),
        .update_pc_i     (update_pc_i),
        .update_target_i (update_target_i),
        .update_taken_i  (update_taken_i),
        .pc_o            (pc_o),
        .pc_plus4_o      (pc_plus4_o),
        .pred_taken_o    (pred_taken_o),
        .pred_target_o   (pred_target_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called just after a negedge: drive this cycle's inputs, queue what
    // must be visible after the coming posedge, then wait for the next negedge.
    task automatic step(input logic st, input logic rd, input logic [31:0] rpc,
                        input logic ue, input logic [31:0] upc, input logic [31:0] utgt,
                        input logic utk,
                        input logic [31:0] epc, input logic ept, input logic [31:0] etgt);
        exp_t e;
        stall_i         = st;
        redirect_i      = rd;
        redirect_pc_i   = rpc;
        update_en_i     = ue;
        update_pc_i     = upc;
        update_target_i = utgt;
        update_taken_i  = utk;
        e.pc  = epc;
        e.pt  = ept;
        e.tgt = etgt;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic nop(input logic [31:0] epc, input logic ept, input logic [31:0] etgt);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, epc, ept, etgt);
    endtask

    task automatic redir(input logic [31:0] rpc, input logic [31:0] epc,
                         input logic ept, input logic [31:0] etgt);
        step(1'b0, 1'b1, rpc, 1'b0, 32'h0, 32'h0, 1'b0, epc, ept, etgt);
    endtask

    // Monitor: one expectation per clock once the driver has queued any.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pc_o",          pc_o,                 e.pc);
                chk("pc_plus4_o",    pc_plus4_o,           e.pc + 32'd4);
                chk("pred_taken_o",  {31'b0, pred_taken_o}, {31'b0, e.pt});
                chk("pred_target_o", pred_target_o,        e.tgt);
            end
        end
    end

    initial begin
        #50000;
        n_chk++;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        // Reset state while rst is held from time zero.
        #1;
        chk("reset_pc",     pc_o,                   32'h0);
        chk("reset_pred",   {31'b0, pred_taken_o},  32'h0);
        chk("reset_target", pred_target_o,          32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("release_pc", pc_o, 32'h0);

        // Run sequentially up to 0x40.
        for (int i = 1; i <= 16; i++) begin
            nop(32'(i * 4), 1'b0, 32'h0);
        end

        // Asynchronous reset mid-cycle: PC clears before any clock edge.
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_pc",   pc_o,                  32'h0);
        chk("async_rst_pred", {31'b0, pred_taken_o}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_pc", pc_o, 32'h0);
        nop(32'h4, 1'b0, 32'h0);
        nop(32'h8, 1'b0, 32'h0);

        // Allocate 0x10 -> 0x80 (taken miss).
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'h10, 32'h80, 1'b1, 32'hC, 1'b0, 32'h0);
        nop(32'h10, B, T);
        nop(N10, 1'b0, 32'h0);

        // Not-taken miss at 0x20 must not allocate.
        step(1'b0, 1'b1, 32'h20, 1'b1, 32'h20, 32'h200, 1'b0, 32'h20, 1'b0, 32'h0);
        nop(32'h24, 1'b0, 32'h0);

        // WEAK_T -> WEAK_NT: hit but predicts fall-through.
        step(1'b0, 1'b1, 32'h10, 1'b1, 32'h10, 32'h80, 1'b0, 32'h10, 1'b0, T);
        nop(32'h14, 1'b0, 32'h0);

        // Three taken: WEAK_NT -> WEAK_T -> STRONG_T -> STRONG_T, then one not-taken.
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'h10, 32'h80, 1'b1, 32'h18, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'h10, 32'h80, 1'b1, 32'h1C, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'h10, 32'h80, 1'b1, 32'h20, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'h10, 32'h80, 1'b0, 32'h24, 1'b0, 32'h0);
        redir(32'h10, 32'h10, B, T);
        nop(N10, 1'b0, 32'h0);

        // Aliasing: same index as 0x10, different tag.
        redir(32'h50, 32'h50, 1'b0, 32'h0);
        nop(32'h54, 1'b0, 32'h0);

        // Stall holds; redirect beats stall and is word aligned.
        redir(32'h20, 32'h20, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h20, 1'b0, 32'h0);
        end
        step(1'b1, 1'b1, 32'h103, 1'b0, 32'h0, 32'h0, 1'b0, 32'h100, 1'b0, 32'h0);
        nop(32'h104, 1'b0, 32'h0);

        // pc_plus4 wraps at the top of the address space.
        redir(32'hFFFF_FFFE, 32'hFFFF_FFFC, 1'b0, 32'h0);
        nop(32'h0, 1'b0, 32'h0);

        // Stall outranks a taken prediction.
        redir(32'h10, 32'h10, B, T);
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h10, B, T);
        // Same-index update while looking up: the lookup uses old contents.
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'h10, 32'h80, 1'b0, N10, 1'b0, 32'h0);
        redir(32'h10, 32'h10, 1'b0, T);

        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
